// File: rtl/bifrost_pkg.sv
// Shared constants for the bifrost interrupt aggregator: register indices,
// source bit positions and the default source count.
package bifrost_pkg;

  localparam int NSRC_DEFAULT = 8;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_PENDING = 3'd1;
  localparam logic [2:0] REG_ENABLE  = 3'd2;
  localparam logic [2:0] REG_MODE    = 3'd3;
  localparam logic [2:0] REG_VECTOR  = 3'd4;

  localparam int SRC_VIA1     = 0;
  localparam int SRC_VIA2     = 1;
  localparam int SRC_UART     = 2;
  localparam int SRC_UART_TXB = 3;
  localparam int SRC_UART_RXB = 4;
  localparam int SRC_UART_TXA = 5;
  localparam int SRC_UART_RXA = 6;
  localparam int SRC_SPARE    = 7;

endpackage

// File: rtl/bifrost_sync.sv
// N-stage flop synchroniser for one asynchronous input; clears to 0 on reset.
module bifrost_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/bifrost_irq.sv
// Interrupt aggregator: synchronises, latches, masks and prioritises the
// peripheral IRQ lines into one registered active-low CPU IRQ.
// Optional vector-pull auto-acknowledge: define BIFROST_IRQ_AUTOACK_EN.
module bifrost_irq
  import bifrost_pkg::*;
#(
  parameter int NSRC        = NSRC_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src_n,
  input  logic            vecpull,
  input  logic            cs,
  input  logic            rw,
  input  logic [2:0]      reg_addr,
  input  logic [7:0]      wdata,
  output logic [7:0]      rdata,
  output logic            irq_n
);

  localparam logic [7:0] VALID_MASK = 8'((16'd1 << NSRC) - 16'd1);

  logic [7:0] asserted;
  logic [7:0] prev_reg, pending_reg, enable_reg, mode_reg;
  logic [7:0] pending_next, active, w1c, mode_chg, edge_set, edge_next, ack_mask;
  logic       irq_n_reg;
  logic       any;
  logic [2:0] idx;
  logic       wr, wr_pending, wr_enable, wr_mode;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_src
      if (gi < NSRC) begin : g_on
        bifrost_sync #(.STAGES(SYNC_STAGES)) u_sync (
          .clock (clock),
          .reset (reset),
          .d     (~irq_src_n[gi]),
          .q     (asserted[gi])
        );
      end else begin : g_off
        assign asserted[gi] = 1'b0;
      end
    end
  endgenerate

  assign wr         = cs & ~rw;
  assign wr_pending = wr && (reg_addr == REG_PENDING);
  assign wr_enable  = wr && (reg_addr == REG_ENABLE);
  assign wr_mode    = wr && (reg_addr == REG_MODE);

  assign active = pending_reg & enable_reg;
  assign any    = |active;

  // Lowest index wins, so scan downwards and let the last hit stick.
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) idx = 3'(i);
    end
  end

`ifdef BIFROST_IRQ_AUTOACK_EN
  logic vp_sync, vp_prev_reg;

  bifrost_sync #(.STAGES(2)) u_vp_sync (
    .clock (clock),
    .reset (reset),
    .d     (~vecpull),
    .q     (vp_sync)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) vp_prev_reg <= 1'b0;
    else       vp_prev_reg <= vp_sync;
  end

  // Only the edge path consumes ack_mask, so level sources are untouched.
  assign ack_mask = (vp_sync && !vp_prev_reg && !irq_n_reg && any) ? (8'd1 << idx) : 8'd0;
`else
  logic unused_vecpull;
  assign unused_vecpull = vecpull;
  assign ack_mask       = 8'd0;
`endif

  assign w1c       = wr_pending ? (wdata & VALID_MASK) : 8'd0;
  assign mode_chg  = wr_mode ? ((wdata & VALID_MASK) ^ mode_reg) : 8'd0;
  assign edge_set  = asserted & ~prev_reg;
  // A new edge overrides any clear arriving on the same cycle.
  assign edge_next = edge_set | (pending_reg & ~(w1c | ack_mask));
  assign pending_next = ((mode_reg & edge_next) | (~mode_reg & asserted))
                        & ~mode_chg & VALID_MASK;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_reg    <= 8'd0;
      pending_reg <= 8'd0;
      enable_reg  <= 8'd0;
      mode_reg    <= 8'd0;
      irq_n_reg   <= 1'b1;
    end else begin
      prev_reg    <= asserted;
      pending_reg <= pending_next;
      if (wr_enable) enable_reg <= wdata & VALID_MASK;
      if (wr_mode)   mode_reg   <= wdata & VALID_MASK;
      irq_n_reg   <= ~any;
    end
  end

  assign irq_n = irq_n_reg;

  always_comb begin
    rdata = 8'h00;
    if (cs) begin
      case (reg_addr)
        REG_STATUS:  rdata = asserted;
        REG_PENDING: rdata = pending_reg;
        REG_ENABLE:  rdata = enable_reg;
        REG_MODE:    rdata = mode_reg;
        REG_VECTOR:  rdata = {any, 4'b0000, idx};
        default:     rdata = 8'h00;
      endcase
    end
  end

endmodule
